online_ccm_sched: RTL and testbench

//   Time-shares one external online constant-coefficient multiplier (e.g. the x19 CCM,

---
 rtl/online_ccm_sched_if.sv | 29 ++
 rtl/online_ccm_sched.sv | 143 ++++++++++++++
 tb/tb_online_ccm_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/online_ccm_sched_if.sv
// Handshake and data bundle between filter-tap requesters, the shared CCM and the result consumer.
// master = requester/consumer/CCM side, slave = scheduler.
interface online_ccm_sched_if #(
   parameter int NREQ   = 4,
   parameter int WL     = 8,
   parameter int WL_OUT = 18,
   parameter int TW     = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*WL-1:0] req_x;
   logic [NREQ-1:0]    req_ready;
   logic               flush;
   logic [WL-1:0]      ccm_x;
   logic [WL_OUT-1:0]  ccm_y;
   logic               res_valid;
   logic [TW-1:0]      res_tag;
   logic [WL_OUT-1:0]  res_y;
   logic               res_ready;

   modport master (
      output req_valid, req_x, flush, ccm_y, res_ready,
      input  req_ready, ccm_x, res_valid, res_tag, res_y
   );

   modport slave (
      input  req_valid, req_x, flush, ccm_y, res_ready,
      output req_ready, ccm_x, res_valid, res_tag, res_y
   );
endinterface

// File: rtl/online_ccm_sched.sv
// Round-robin time-sharing of one combinational online CCM among NREQ requesters; CCM_SCHED_STATS_EN adds grant counters and state.
// Latency: handshake at edge t gives res_valid at edge t+LAT+1, one op per clock when unstalled.
// Backpressure: res_valid & ~res_ready freezes ccm_x and the whole pipeline and withholds every grant; flush overrides.
module online_ccm_sched #(
   parameter int Stage = 4,
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int SH    = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   online_ccm_sched_if.slave  bus
`ifdef CCM_SCHED_STATS_EN
   ,
   output logic [NREQ*16-1:0] grant_cnt,
   output logic [1:0]         sched_state
`endif
);
   localparam int WL     = 2*Stage;
   localparam int WL_OUT = 2*(Stage+SH);
   localparam int TW     = $clog2(NREQ);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic              stall;
   logic              hs;
   logic [NREQ-1:0]   grant;
   logic [TW-1:0]     gnt_idx;
   logic [TW-1:0]     scan_idx;
   logic [TW-1:0]     ptr;
   logic [TW-1:0]     ptr_nxt;
   logic [WL-1:0]     sel_x;
   logic [TW-1:0]     iss_tag;
   logic              iss_v;
   logic [WL_OUT-1:0] pipe_y   [LAT+1];
   logic [TW-1:0]     pipe_tag [LAT+1];
   logic [LAT:0]      pipe_v;
   logic              drain_empty;
   logic [1:0]        state;
   logic [1:0]        state_nxt;

   assign stall = pipe_v[LAT] & ~bus.res_ready;

   // Descending scan so the smallest offset from ptr is the last (winning) assignment.
   always_comb begin
      grant    = '0;
      gnt_idx  = '0;
      scan_idx = '0;
      if (!stall && !bus.flush) begin
         for (int k = NREQ-1; k >= 0; k--) begin
            scan_idx = TW'((int'(ptr) + k) % NREQ);
            if (bus.req_valid[scan_idx]) begin
               grant           = '0;
               grant[scan_idx] = 1'b1;
               gnt_idx         = scan_idx;
            end
         end
      end
   end

   assign hs            = |grant;
   assign bus.req_ready = grant;
   assign sel_x         = bus.req_x[gnt_idx*WL +: WL];
   assign ptr_nxt       = (gnt_idx == TW'(NREQ-1)) ? '0 : gnt_idx + TW'(1);

   assign bus.res_valid = pipe_v[LAT];
   assign bus.res_tag   = pipe_tag[LAT];
   assign bus.res_y     = pipe_y[LAT];

   // Data registers load only behind a valid bit, so bubbles cost no toggling.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         bus.ccm_x <= '0;
         iss_tag   <= '0;
         iss_v     <= 1'b0;
         pipe_v    <= '0;
         state     <= ST_IDLE;
         for (int k = 0; k <= LAT; k++) begin
            pipe_y[k]   <= '0;
            pipe_tag[k] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (bus.flush) begin
            iss_v  <= 1'b0;
            pipe_v <= '0;
         end else if (!stall) begin
            iss_v  <= hs;
            pipe_v <= {pipe_v[LAT-1:0], iss_v};
            if (hs) begin
               bus.ccm_x <= sel_x;
               iss_tag   <= gnt_idx;
               ptr       <= ptr_nxt;
            end
            if (iss_v) begin
               pipe_y[0]   <= bus.ccm_y;
               pipe_tag[0] <= iss_tag;
            end
            for (int k = 1; k <= LAT; k++) begin
               if (pipe_v[k-1]) begin
                  pipe_y[k]   <= pipe_y[k-1];
                  pipe_tag[k] <= pipe_tag[k-1];
               end
            end
         end
      end
   end

   assign drain_empty = !hs && !iss_v && (pipe_v[LAT-1:0] == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (hs) state_nxt = ST_RUN;
         ST_RUN: begin
            if (stall)            state_nxt = ST_HOLD;
            else if (drain_empty) state_nxt = ST_IDLE;
         end
         ST_HOLD: if (bus.res_ready) state_nxt = ST_RUN;
         default: state_nxt = ST_IDLE;
      endcase
      if (bus.flush) state_nxt = ST_IDLE;
   end

`ifdef CCM_SCHED_STATS_EN
   // Counters survive flush; only rst_n clears them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
         end
      end
   end

   assign sched_state = state;
`endif
endmodule

// File: tb/tb_online_ccm_sched.sv
// Directed and random stimulus against a queue-based reference model of the scheduler.
// The CCM is modelled as an injective combinational function of ccm_x.
module tb_online_ccm_sched;
   localparam int NREQ   = 4;
   localparam int WL     = 8;
   localparam int WL_OUT = 18;
   localparam int TW     = 2;
   localparam int DEPTH  = 3;

   typedef struct {
      logic [TW-1:0]     tag;
      logic [WL_OUT-1:0] y;
      int                age;
   } item_t;

   logic clk = 1'b0;
   logic rst_n;

   online_ccm_sched_if #(.NREQ(NREQ), .WL(WL), .WL_OUT(WL_OUT), .TW(TW)) bus ();

   online_ccm_sched #(.Stage(4), .NREQ(NREQ), .LAT(2), .SH(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [WL_OUT-1:0] ccm_fn(input logic [WL-1:0] x);
      return (WL_OUT'(x) * 18'd19) ^ {x, 10'h2A5};
   endfunction

   assign bus.ccm_y = ccm_fn(bus.ccm_x);

   item_t         q[$];
   int            m_ptr;
   logic [WL-1:0] m_ccm_x;
   bit            m_fresh;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check registered outputs, drive inputs, check the grant, advance the model over the edge.
   task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ*WL-1:0] x,
                      input logic rr, input logic fl, input logic rst);
      logic [NREQ-1:0] exp_g;
      bit              vis;
      bit              m_stall;
      int              gi;
      item_t           it;
      @(negedge clk);
      vis = (q.size() > 0) && (q[0].age == DEPTH);
      chk("res_valid", 32'(bus.res_valid), 32'(vis));
      chk("ccm_x", 32'(bus.ccm_x), 32'(m_ccm_x));
      if (vis) begin
         chk("res_tag", 32'(bus.res_tag), 32'(q[0].tag));
         chk("res_y", 32'(bus.res_y), 32'(q[0].y));
      end else if (m_fresh) begin
         chk("res_tag_rst", 32'(bus.res_tag), 32'd0);
         chk("res_y_rst", 32'(bus.res_y), 32'd0);
      end
      m_fresh = 1'b0;

      bus.req_valid = v;
      bus.req_x     = x;
      bus.res_ready = rr;
      bus.flush     = fl;
      rst_n         = ~rst;
      #1;
      m_stall = vis && !rr;
      exp_g   = '0;
      gi      = -1;
      if (!m_stall && !fl) begin
         for (int k = 0; k < NREQ; k++)
            if (gi < 0 && v[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
      end
      if (gi >= 0) exp_g[gi] = 1'b1;
      if (!rst) chk("req_ready", 32'(bus.req_ready), 32'(exp_g));

      if (rst) begin
         q.delete();
         m_ptr   = 0;
         m_ccm_x = '0;
         m_fresh = 1'b1;
      end else if (fl) begin
         q.delete();
      end else if (!m_stall) begin
         if (vis) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (gi >= 0) begin
            it.tag  = TW'(gi);
            it.y    = ccm_fn(x[gi*WL +: WL]);
            it.age  = 0;
            q.push_back(it);
            m_ptr   = (gi + 1) % NREQ;
            m_ccm_x = x[gi*WL +: WL];
         end
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_x     = '0;
      bus.res_ready = 1'b1;
      bus.flush     = 1'b0;
      m_ptr         = 0;
      m_ccm_x       = '0;
      m_fresh       = 1'b1;

      cyc('0, '0, 1'b1, 1'b0, 1'b1);
      repeat (10) cyc('0, '0, 1'b1, 1'b0, 1'b0);

      // single op from requester 0
      cyc(4'b0001, {24'h0, 8'hA5}, 1'b1, 1'b0, 1'b0);
      repeat (5) cyc('0, '0, 1'b1, 1'b0, 1'b0);

      // all requesters busy, consumer always ready
      repeat (12) cyc(4'hF, $urandom, 1'b1, 1'b0, 1'b0);

      // consumer stalls for 4 clocks while full, then releases
      repeat (4) cyc(4'hF, $urandom, 1'b0, 1'b0, 1'b0);
      repeat (8) cyc(4'hF, $urandom, 1'b1, 1'b0, 1'b0);

      // flush with ops in flight, then a lone op from requester 2
      cyc(4'hF, $urandom, 1'b1, 1'b1, 1'b0);
      cyc(4'b0100, {8'h0, 8'h3C, 16'h0}, 1'b1, 1'b0, 1'b0);
      repeat (5) cyc('0, '0, 1'b1, 1'b0, 1'b0);

      // one-clock reset mid-stream
      repeat (3) cyc(4'hF, $urandom, 1'b1, 1'b0, 1'b0);
      cyc(4'hF, $urandom, 1'b1, 1'b0, 1'b1);
      repeat (6) cyc(4'hF, $urandom, 1'b1, 1'b0, 1'b0);

      // random traffic with backpressure, occasional flush and reset
      repeat (400)
         cyc(4'($urandom), $urandom, ($urandom % 4) != 0,
             ($urandom % 25) == 0, ($urandom % 60) == 0);
      repeat (6) cyc('0, '0, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
